next_pc_unit: RTL and testbench

- Program-counter stage of the RV32I core. It sits directly downstream of the branch-condition unit and consumes its Branch flag.
- Holds the architectural PC and selects the next PC from: PC+4, branch target, JAL target or JALR target.
- Gates PC advance with an instruction-fetch handshake and a pipeline stall.
- Counts retired instructions.

---
 rtl/rv32_pkg.sv | 24 ++
 rtl/next_pc_unit_imm_gen.sv | 20 ++
 rtl/next_pc_unit.sv | 126 ++++++++++++
 tb/tb_next_pc_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the PC stage and its decoders.
// The TRAP state exists only when NEXT_PC_MISALIGN_TRAP_EN is defined.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;

`ifdef NEXT_PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_TRAP
    } state_t;
`else
    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } state_t;
`endif

endpackage

// File: rtl/next_pc_unit_imm_gen.sv
// Immediate decoder for B, J and I formats, sign-extended to XLEN.
// Shared with the ALU-source path.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [XLEN-1:7] i_instr,
    output logic [XLEN-1:0] o_imm_b,
    output logic [XLEN-1:0] o_imm_j,
    output logic [XLEN-1:0] o_imm_i
);

    assign o_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};

    assign o_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};

    assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};

endmodule

// File: rtl/next_pc_unit.sv
// RV32I program-counter stage: next-PC select, fetch handshake, retire count.
// Define NEXT_PC_MISALIGN_TRAP_EN to trap on misaligned targets.
module next_pc_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] Instruction,
    input  logic [XLEN-1:0] rs1Data,
    input  logic            Branch,
    input  logic            stall,
    input  logic            fetch_ack,
    output logic            fetch_req,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] LinkAddr,
    output logic            Redirect,
    output logic [XLEN-1:0] retired,
    output logic            trap
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_retired;

    logic [6:0]      w_op;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_target;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_take_br;
    logic            w_adv;
    logic            w_misalign;

    imm_gen u_imm_gen (
        .i_instr (Instruction[XLEN-1:7]),
        .o_imm_b (w_imm_b),
        .o_imm_j (w_imm_j),
        .o_imm_i (w_imm_i)
    );

    assign w_op      = Instruction[6:0];
    assign w_is_jal  = (w_op == OP_JAL);
    assign w_is_jalr = (w_op == OP_JALR);
    assign w_take_br = (w_op == OP_BRANCH) & Branch;
    assign w_pc4     = r_pc + 32'd4;

    // Opcode tests are mutually exclusive, so priority collapses to unique.
    always_comb begin
        w_target = w_pc4;
        unique case (1'b1)
            w_is_jal:  w_target = r_pc + w_imm_j;
            w_is_jalr: w_target = (rs1Data + w_imm_i) & ~32'h1;
            w_take_br: w_target = r_pc + w_imm_b;
            default:   w_target = w_pc4;
        endcase
    end

    assign w_adv = (r_state == ST_RUN) & fetch_ack & ~stall;

`ifdef NEXT_PC_MISALIGN_TRAP_EN
    assign w_misalign = (w_target[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
`ifdef NEXT_PC_MISALIGN_TRAP_EN
                if (w_adv && w_misalign) begin
                    w_state_nxt = ST_TRAP;
                end
`endif
            end
`ifdef NEXT_PC_MISALIGN_TRAP_EN
            ST_TRAP: w_state_nxt = ST_RUN;
`endif
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A trapping advance loads the vector and does not count as a retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_retired <= '0;
        end else if (w_adv) begin
            if (w_misalign) begin
                r_pc <= TRAP_VEC;
            end else begin
                r_pc      <= w_target & ~32'h3;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign PC        = r_pc;
    assign LinkAddr  = w_pc4;
    assign Redirect  = w_is_jal | w_is_jalr | w_take_br;
    assign retired   = r_retired;
    assign fetch_req = (r_state == ST_RUN);

`ifdef NEXT_PC_MISALIGN_TRAP_EN
    assign trap = (r_state == ST_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: behavioural model plus directed vectors.
// Honours NEXT_PC_MISALIGN_TRAP_EN for the misaligned-target expectations.
module tb_next_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TVEC   = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JALR0  = 32'h0000_8067;
    localparam logic [31:0] BEQM4  = 32'hFE00_0EE3;
    localparam logic [31:0] JAL800 = 32'h0010_006F;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction;
    logic [31:0] rs1Data;
    logic        Branch;
    logic        stall;
    logic        fetch_ack;
    logic        fetch_req;
    logic [31:0] PC;
    logic [31:0] LinkAddr;
    logic        Redirect;
    logic [31:0] retired;
    logic        trap;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: phase 0 = boot, 1 = running, 2 = trap cycle.
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    int          m_phase;

    next_pc_unit #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
        .clk         (clk),
        .reset       (reset),
        .Instruction (Instruction),
        .rs1Data     (rs1Data),
        .Branch      (Branch),
        .stall       (stall),
        .fetch_ack   (fetch_ack),
        .fetch_req   (fetch_req),
        .PC          (PC),
        .LinkAddr    (LinkAddr),
        .Redirect    (Redirect),
        .retired     (retired),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit f_redirect(input logic [31:0] ins, input logic br);
        return ins[6:0] == 7'h6F || ins[6:0] == 7'h67 ||
               (ins[6:0] == 7'h63 && br);
    endfunction

    function automatic logic [31:0] f_target(input logic [31:0] pc,
                                             input logic [31:0] ins,
                                             input logic [31:0] rs1,
                                             input logic br);
        int imm_b;
        int imm_j;
        int imm_i;
        imm_b = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        imm_j = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        imm_i = $signed(ins[31:20]);
        if (ins[6:0] == 7'h6F) return pc + imm_j;
        if (ins[6:0] == 7'h67) return (rs1 + imm_i) & 32'hFFFF_FFFE;
        if (ins[6:0] == 7'h63 && br) return pc + imm_b;
        return pc + 4;
    endfunction

    always @(posedge clk) begin
        logic [31:0] t;
        if (reset) begin
            m_pc    = RST_PC;
            m_ret   = 0;
            m_phase = 0;
        end else if (m_phase != 1) begin
            m_phase = 1;
        end else if (fetch_ack && !stall) begin
            t = f_target(m_pc, Instruction, rs1Data, Branch);
`ifdef NEXT_PC_MISALIGN_TRAP_EN
            if (t % 4 != 0) begin
                m_pc    = TVEC;
                m_phase = 2;
            end else begin
                m_pc  = t;
                m_ret = m_ret + 1;
            end
`else
            m_pc  = t & 32'hFFFF_FFFC;
            m_ret = m_ret + 1;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_pc", PC, m_pc);
            chk("m_retired", retired, m_ret);
            chk("m_fetch_req", {31'd0, fetch_req}, {31'd0, m_phase == 1});
            chk("m_trap", {31'd0, trap}, {31'd0, m_phase == 2});
            chk("m_linkaddr", LinkAddr, m_pc + 4);
            chk("m_redirect", {31'd0, Redirect},
                {31'd0, f_redirect(Instruction, Branch)});
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_to(input logic [31:0] addr);
        Instruction = JALR0;
        rs1Data     = addr;
        Branch      = 1'b0;
        stall       = 1'b0;
        fetch_ack   = 1'b1;
        cyc();
    endtask

    logic [31:0] ret0;

    initial begin
        reset       = 1'b1;
        Instruction = NOP;
        rs1Data     = 32'd0;
        Branch      = 1'b0;
        stall       = 1'b0;
        fetch_ack   = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_pc", PC, 32'h0);
        chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);

        reset     = 1'b0;
        fetch_ack = 1'b1;
        cyc();
        chk("boot_fetch_req", {31'd0, fetch_req}, 32'd1);
        chk("boot_pc", PC, 32'h0);
        cyc();
        chk("nop1_pc", PC, 32'h4);
        cyc(2);
        chk("nop3_pc", PC, 32'hC);
        chk("nop3_retired", retired, 32'd3);

        fetch_ack = 1'b0;
        cyc(2);
        chk("noack_pc", PC, 32'hC);
        fetch_ack = 1'b1;

        go_to(32'h40);
        Instruction = BEQM4;
        Branch      = 1'b1;
        #1;
        chk("beq_redirect", {31'd0, Redirect}, 32'd1);
        cyc();
        chk("beq_taken_pc", PC, 32'h3C);

        go_to(32'h40);
        Instruction = BEQM4;
        Branch      = 1'b0;
        #1;
        chk("beq_nt_redirect", {31'd0, Redirect}, 32'd0);
        cyc();
        chk("beq_nt_pc", PC, 32'h44);

        Instruction = NOP;
        Branch      = 1'b1;
        #1;
        chk("nop_br_redirect", {31'd0, Redirect}, 32'd0);
        cyc();
        chk("nop_br_pc", PC, 32'h48);
        Branch = 1'b0;

        go_to(32'h10);
        Instruction = JAL800;
        #1;
        chk("jal_link", LinkAddr, 32'h14);
        chk("jal_redirect", {31'd0, Redirect}, 32'd1);
        cyc();
        chk("jal_pc", PC, 32'h810);

        go_to(32'h1001);
        chk("jalr_pc", PC, 32'h1000);

        Instruction = NOP;
        ret0        = retired;
        stall       = 1'b1;
        cyc(2);
        chk("stall_pc", PC, 32'h1000);
        chk("stall_retired", retired, ret0);
        chk("stall_fetch_req", {31'd0, fetch_req}, 32'd1);
        stall = 1'b0;
        cyc();
        chk("unstall_pc", PC, 32'h1004);
        chk("unstall_retired", retired, ret0 + 1);

        ret0 = retired;
        go_to(32'h1002);
`ifdef NEXT_PC_MISALIGN_TRAP_EN
        chk("mis_pc", PC, 32'h100);
        chk("mis_trap", {31'd0, trap}, 32'd1);
        chk("mis_fetch_req", {31'd0, fetch_req}, 32'd0);
        chk("mis_retired", retired, ret0);
        Instruction = NOP;
        cyc();
        chk("mis_trap_end", {31'd0, trap}, 32'd0);
        chk("mis_hold_pc", PC, 32'h100);
`else
        chk("mis_pc", PC, 32'h1000);
        chk("mis_trap", {31'd0, trap}, 32'd0);
        chk("mis_retired", retired, ret0 + 1);
`endif

        go_to(32'h80);
        Instruction = NOP;
        stall       = 1'b1;
        cyc();
        reset = 1'b1;
        cyc();
        chk("rst_stall_pc", PC, RST_PC);
        chk("rst_stall_retired", retired, 32'd0);
        chk("rst_stall_fetch_req", {31'd0, fetch_req}, 32'd0);
        reset = 1'b0;
        stall = 1'b0;
        cyc();

        go_to(32'hFFFF_FFFC);
        Instruction = NOP;
        #1;
        chk("wrap_link", LinkAddr, 32'h0);
        cyc();
        chk("wrap_pc", PC, 32'h0);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
